pwm_load_arbiter: RTL and testbench
===================================

PWM_LOAD_ARBITER -- requirements
Module: pwm_load_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the Load data width in bits.
REQ-002 The block SHALL have parameter MAX_LOAD, default 1000, giving the highest counter value forwarded to the PWM.
REQ-003 The block SHALL have parameter PULSE_LEN, default 3, giving the Load_en high time in cycles (legal range >= 2).
REQ-004 The block SHALL have parameter GAP_LEN, default 4, giving the Load_en low time in cycles after the pulse (legal range >= 2).
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock; all state is on the rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port Req0, input, 1 bit: load request from requester 0 (host).
REQ-008 The block SHALL have port Load0, input, WIDTH bits: value requested by requester 0.
REQ-009 The block SHALL have port Gnt0, output, 1 bit: one-cycle grant to requester 0.
REQ-010 The block SHALL have port Req1, input, 1 bit: load request from requester 1 (ramp/sync source).
REQ-011 The block SHALL have port Load1, input, WIDTH bits: value requested by requester 1.
REQ-012 The block SHALL have port Gnt1, output, 1 bit: one-cycle grant to requester 1.
REQ-013 The block SHALL have port Load, output, WIDTH bits: registered value driven to the PWM Load input.
REQ-014 The block SHALL have port Load_en, output, 1 bit: registered strobe driven to the PWM Load_en input.
REQ-015 The block SHALL have port Busy, output, 1 bit: high while a load transaction is in progress.
REQ-016 The block SHALL have port Clamp, output, 1 bit: one-cycle flag, high when the granted value was clamped.

Function
REQ-017 The FSM SHALL have three states: IDLE, PULSE and GAP.
REQ-018 In IDLE, on a rising edge with Req0 or Req1 high, the FSM SHALL register the winner's clamped value into Load, assert the winner's Gnt and Clamp (if applicable) for exactly the next cycle, set Load_en high and enter PULSE.
REQ-019 Arbitration SHALL be round-robin: a lone request wins; on simultaneous requests, the requester not granted last wins; after reset requester 0 has priority.
REQ-020 Clamping SHALL be: value > MAX_LOAD -> MAX_LOAD with Clamp=1; otherwise the value passes unchanged with Clamp=0; the compare is unsigned over WIDTH bits.
REQ-021 In PULSE, Load_en SHALL stay high for exactly PULSE_LEN cycles; the FSM SHALL then drop Load_en and enter GAP.
REQ-022 In GAP, Load_en SHALL stay low for exactly GAP_LEN cycles; the FSM SHALL then return to IDLE.
REQ-023 Load SHALL remain constant from the capture edge until the next capture, so the value is stable throughout the PWM's 2-cycle synchronizer and edge detection.
REQ-024 Busy SHALL be high in PULSE and GAP and low in IDLE.
REQ-025 The minimum spacing between consecutive grants SHALL be PULSE_LEN+GAP_LEN+1 cycles (default 8).
REQ-026 Requests SHALL be level-sensitive: a requester holds Req and data stable until its Gnt; Req deasserted before grant is a legal withdrawal and SHALL NOT be granted.
REQ-027 Requests arriving while Busy SHALL be ignored until IDLE; no request SHALL be queued internally.
REQ-028 A requester SHALL NOT receive Gnt while its Req is low; Gnt0 and Gnt1 SHALL never be high together.
REQ-029 The internal cycle counter SHALL be just wide enough for max(PULSE_LEN, GAP_LEN) and SHALL reload on each state entry.

Reset
REQ-030 While Reset_n is low, the block SHALL asynchronously force: state=IDLE, Load=0, Load_en=0, Gnt0=Gnt1=0, Busy=0, Clamp=0, round-robin priority to requester 0, counter=0.
REQ-031 Reset asserted mid-PULSE SHALL drop Load_en immediately; the interrupted transaction SHALL be lost and SHALL NOT resume after reset.
REQ-032 Release of Reset_n SHALL take effect on the first rising edge with Reset_n sampled high; a Req held high then SHALL be granted on that edge.

Verification
REQ-033 Scenario single load: Req0=1 with Load0=300 -> Gnt0 pulses 1 cycle, Load=300, Load_en high 3 cycles then low 4, Busy high 7 cycles.
REQ-034 Scenario clamp: Req1=1 with Load1=4000 -> Load=1000, Clamp=1 for 1 cycle, Gnt1 pulses once.
REQ-035 Scenario contention: Req0 and Req1 both held high (Load0=100, Load1=200) -> grants alternate 0,1,0,1 every 8 cycles; Load follows 100,200,100.
REQ-036 Scenario withdrawal: Req1 raised during Busy and dropped before IDLE -> no Gnt1, Load unchanged.
REQ-037 Scenario mid-operation reset: Reset_n low during the 2nd PULSE cycle -> Load_en=0 and Load=0 immediately; after release with Req1=1 held high, Gnt1 is issued on the first edge (priority state 0, only requester 1 pending).
REQ-038 Scenario system: with the PWM block attached, a load of 600 -> the PWM counter equals 600 within 4 cycles of Load_en rising and PWM_o=1.

Source files
------------

// File: rtl/pwm_load_arbiter.sv
// Round-robin arbiter that forwards a clamped load value to a PWM as a Load/Load_en transaction.
// Latency: grant, Load and Load_en are registered one cycle after the capture edge; grants are at least PULSE_LEN+GAP_LEN+1 cycles apart.
// Backpressure: requesters hold Req until Gnt; requests seen while Busy are not queued.
module pwm_load_arbiter #(
    parameter int WIDTH     = 12,
    parameter int MAX_LOAD  = 1000,
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Load0,
    output logic             Gnt0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Load1,
    output logic             Gnt1,
    output logic [WIDTH-1:0] Load,
    output logic             Load_en,
    output logic             Busy,
    output logic             Clamp
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN);
    localparam logic [CNT_W-1:0] PULSE_RLD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_RLD   = CNT_W'(GAP_LEN - 1);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_LOAD);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             prio;
    logic             capture;
    logic             win;
    logic [WIDTH-1:0] win_val;
    logic             win_clamp;

    // prio names the requester that wins a tie; it flips to the loser after every grant
    always_comb begin
        capture   = (state == IDLE) && (Req0 || Req1);
        win       = (Req0 && Req1) ? prio : Req1;
        win_val   = win ? Load1 : Load0;
        win_clamp = (win_val > MAX_VAL);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = PULSE;
                    cnt_nxt   = PULSE_RLD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_RLD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            prio    <= 1'b0;
            Load    <= '0;
            Load_en <= 1'b0;
            Busy    <= 1'b0;
            Gnt0    <= 1'b0;
            Gnt1    <= 1'b0;
            Clamp   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            Load_en <= (state_nxt == PULSE);
            Busy    <= (state_nxt != IDLE);
            Gnt0    <= capture && !win;
            Gnt1    <= capture && win;
            Clamp   <= capture && win_clamp;
            // Load only changes on a capture so the PWM synchronizer always sees a stable value
            if (capture) begin
                Load <= win_clamp ? MAX_VAL : win_val;
                prio <= ~win;
            end
        end
    end

endmodule

// File: tb/tb_pwm_load_arbiter.sv
// Scoreboard bench for pwm_load_arbiter with a small PWM load-path model attached.
module tb_pwm_load_arbiter;

    localparam int W = 12;

    logic         Clock;
    logic         Reset_n;
    logic         Req0, Req1;
    logic [W-1:0] Load0, Load1;
    logic         Gnt0, Gnt1;
    logic [W-1:0] Load;
    logic         Load_en, Busy, Clamp;

    typedef struct {
        int         id;
        logic [W-1:0] val;
        logic       clamp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   tb_prio = 1'b0;

    pwm_load_arbiter #(
        .WIDTH(W), .MAX_LOAD(1000), .PULSE_LEN(3), .GAP_LEN(4)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .Load0(Load0), .Gnt0(Gnt0),
        .Req1(Req1), .Load1(Load1), .Gnt1(Gnt1),
        .Load(Load), .Load_en(Load_en), .Busy(Busy), .Clamp(Clamp)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // PWM input side: 2-flop synchronizer on Load_en, rising-edge detect, counter load
    logic [2:0]   pwm_sync;
    logic [W-1:0] pwm_cnt;
    logic         pwm_o;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pwm_sync <= '0;
            pwm_cnt  <= '0;
            pwm_o    <= 1'b0;
        end else begin
            pwm_sync <= {pwm_sync[1:0], Load_en};
            if (pwm_sync[1] && !pwm_sync[2]) begin
                pwm_cnt <= Load;
                pwm_o   <= 1'b1;
            end
        end
    end

    // Expected grant for a request pattern, following round-robin priority
    function automatic exp_t predict(input bit r0, input bit r1, input logic [W-1:0] v0,
                                     input logic [W-1:0] v1);
        exp_t e;
        e.id    = (r0 && r1) ? int'(tb_prio) : (r1 ? 1 : 0);
        e.val   = (e.id == 1) ? v1 : v0;
        e.clamp = (e.val > 12'd1000);
        if (e.clamp) e.val = 12'd1000;
        return e;
    endfunction

    task automatic wait_grant(input int budget, output int who, output int waited, output bit timed_out);
        who = -1; waited = 0; timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            waited = i + 1;
            if (Gnt0 || Gnt1) begin
                who = Gnt1 ? 1 : 0;
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic push_req(input bit r0, input bit r1);
        exp_t e;
        e = predict(r0, r1, Load0, Load1);
        sb.push_back(e);
        tb_prio = (e.id == 0);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Load0 = '0; Load1 = '0;
        tb_prio = 1'b0;
        repeat (2) @(negedge Clock);
        n_cmp++;
        if (Load !== 12'd0) begin
            n_err++; $display("FAIL reset_load: got %0d want 0", Load);
        end
        n_cmp++;
        if ({Load_en, Busy, Gnt0, Gnt1, Clamp} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: en/busy/g0/g1/clamp got %b want 00000",
                              {Load_en, Busy, Gnt0, Gnt1, Clamp});
        end
        Reset_n = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b want 0", Busy);
        end
    endtask

    task automatic test_single();
        exp_t e; int who, waited; bit to;
        Load0 = 12'd300; Req0 = 1'b1;
        push_req(1'b1, 1'b0);
        wait_grant(4, who, waited, to);
        Req0 = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (to || who !== e.id || Load !== e.val || Clamp !== e.clamp) begin
            n_err++; $display("FAIL single_grant: to=%0d who=%0d load=%0d clamp=%b want who=%0d load=%0d clamp=%b",
                              to, who, Load, Clamp, e.id, e.val, e.clamp);
        end
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge Clock);
            n_cmp++;
            if ({Load_en, Busy} !== {c <= 3, c <= 7} || Load !== 12'd300 || (c > 1 && Gnt0 !== 1'b0)) begin
                n_err++; $display("FAIL single_cycle%0d: en=%b busy=%b load=%0d gnt0=%b want en=%b busy=%b load=300",
                                  c, Load_en, Busy, Load, Gnt0, c <= 3, c <= 7);
            end
        end
    endtask

    task automatic test_clamp();
        logic [W-1:0] vals [5];
        exp_t e; int who, waited; bit to;
        vals = '{12'd4000, 12'd1000, 12'd1001, 12'd0, 12'd4095};
        for (int k = 0; k < 5; k++) begin
            Load1 = vals[k]; Req1 = 1'b1;
            push_req(1'b0, 1'b1);
            wait_grant(10, who, waited, to);
            Req1 = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (to || who !== e.id || Load !== e.val || Clamp !== e.clamp) begin
                n_err++; $display("FAIL clamp_%0d: to=%0d who=%0d load=%0d clamp=%b want who=%0d load=%0d clamp=%b",
                                  vals[k], to, who, Load, Clamp, e.id, e.val, e.clamp);
            end
            @(negedge Clock);
            n_cmp++;
            if (Clamp !== 1'b0 || Gnt1 !== 1'b0) begin
                n_err++; $display("FAIL clamp_pulse_%0d: clamp=%b gnt1=%b want 0 0", vals[k], Clamp, Gnt1);
            end
            repeat (7) @(negedge Clock);
        end
    endtask

    task automatic test_contention();
        exp_t e; int who, waited; bit to;
        Load0 = 12'd100; Load1 = 12'd200; Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 0; k < 4; k++) push_req(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(12, who, waited, to);
            e = sb.pop_front();
            n_cmp++;
            if (to || who !== e.id || Load !== e.val || (Gnt0 && Gnt1)) begin
                n_err++; $display("FAIL contention_%0d: to=%0d who=%0d load=%0d g0=%b g1=%b want who=%0d load=%0d",
                                  k, to, who, Load, Gnt0, Gnt1, e.id, e.val);
            end
            if (k > 0) begin
                n_cmp++;
                if (waited !== 8) begin
                    n_err++; $display("FAIL contention_spacing_%0d: got %0d cycles want 8", k, waited);
                end
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (8) @(negedge Clock);
    endtask

    task automatic test_withdrawal();
        exp_t e; int who, waited, gcount; bit to;
        Load0 = 12'd700; Req0 = 1'b1;
        push_req(1'b1, 1'b0);
        wait_grant(4, who, waited, to);
        Req0 = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (to || who !== e.id || Load !== e.val) begin
            n_err++; $display("FAIL withdraw_grant: to=%0d who=%0d load=%0d want who=%0d load=%0d",
                              to, who, Load, e.id, e.val);
        end
        gcount = 0;
        for (int c = 2; c <= 16; c++) begin
            @(negedge Clock);
            if (c == 2) begin Load1 = 12'd55; Req1 = 1'b1; end
            if (c == 6) Req1 = 1'b0;
            if (Gnt0 || Gnt1) gcount++;
        end
        n_cmp++;
        if (gcount !== 0 || Load !== 12'd700 || Busy !== 1'b0) begin
            n_err++; $display("FAIL withdraw_nogrant: grants=%0d load=%0d busy=%b want 0 700 0", gcount, Load, Busy);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; int who, waited; bit to;
        Load0 = 12'd500; Req0 = 1'b1;
        push_req(1'b1, 1'b0);
        wait_grant(4, who, waited, to);
        Req0 = 1'b0;
        e = sb.pop_front();
        @(negedge Clock);
        n_cmp++;
        if (to || who !== e.id || Load_en !== 1'b1 || Load !== 12'd500) begin
            n_err++; $display("FAIL midreset_pre: to=%0d who=%0d en=%b load=%0d want who=0 en=1 load=500",
                              to, who, Load_en, Load);
        end
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (Load_en !== 1'b0 || Load !== 12'd0 || Busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_async: en=%b load=%0d busy=%b want 0 0 0", Load_en, Load, Busy);
        end
        tb_prio = 1'b0;
        Load1 = 12'd250; Req1 = 1'b1;
        push_req(1'b0, 1'b1);
        @(negedge Clock);
        Reset_n = 1'b1;
        wait_grant(1, who, waited, to);
        Req1 = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (to || who !== e.id || Load !== e.val || Load_en !== 1'b1) begin
            n_err++; $display("FAIL midreset_release: to=%0d who=%0d load=%0d en=%b want who=1 load=250 en=1",
                              to, who, Load, Load_en);
        end
        repeat (8) @(negedge Clock);
    endtask

    task automatic test_system();
        exp_t e; int who, waited, hit; bit to;
        Load0 = 12'd600; Req0 = 1'b1;
        push_req(1'b1, 1'b0);
        wait_grant(4, who, waited, to);
        Req0 = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (to || who !== e.id || Load !== e.val || Load_en !== 1'b1) begin
            n_err++; $display("FAIL system_grant: to=%0d who=%0d load=%0d en=%b want who=0 load=600 en=1",
                              to, who, Load, Load_en);
        end
        hit = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clock);
            if (hit == 0 && pwm_cnt == 12'd600 && pwm_o) hit = c;
        end
        n_cmp++;
        if (hit == 0) begin
            n_err++; $display("FAIL system_pwm: pwm_cnt=%0d pwm_o=%b want 600 and 1 within 4 cycles", pwm_cnt, pwm_o);
        end
        repeat (6) @(negedge Clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_contention();
        test_withdrawal();
        test_mid_reset();
        test_system();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
